// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR tap scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fir_pkg;

  localparam int DW     = 16;
  localparam int QSHIFT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/fir_tap_scheduler_if.sv
// Sample, result and coefficient-config signals of the FIR tap scheduler.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the sample and the result side.
interface fir_tap_scheduler_if #(
  parameter int NTAPS = 8
) ();
  import fir_pkg::*;

  localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          ovf;
  logic          busy;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, ovf, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, ovf, busy
  );

endinterface

// File: rtl/fir_tap_scheduler_rca_16bit.sv
// rca_16bit: plain 16-bit ripple-carry adder, the shared accumulate adder.
// Latency: combinational.
// Backpressure: none.
module rca_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] cy;

  assign cy[0] = c;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end

  assign cout = cy[16];

endmodule

// File: rtl/fir_tap_scheduler.sv
// Time-multiplexed FIR: one sample per accept, NTAPS accumulate cycles on one adder.
// Latency: accept in cycle T, out_valid from T+NTAPS+1; min sample interval NTAPS+2.
// Backpressure: result held in OUT until out_ready; no sample accepted outside IDLE.
// Optional: define FIR_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module fir_tap_scheduler
  import fir_pkg::*;
#(
  parameter int NTAPS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fir_tap_scheduler_if.slave   bus
);

  localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  state_t               state_q, state_d;
  logic signed [DW-1:0] x_q    [NTAPS];
  logic signed [DW-1:0] coef_q [NTAPS];
  logic signed [DW-1:0] acc_q;
  logic        [AW-1:0] idx_q;
  logic                 ovf_q;

  logic                   accept;
  logic                   acc_step;
  logic                   cfg_wr;
  logic signed [2*DW-1:0] prod;
  logic signed [DW-1:0]   term;
  logic        [DW-1:0]   sum;
  logic                   add_cout_unused;
  logic                   add_ovf;
  logic signed [DW-1:0]   acc_next;

  // Single shared accumulate adder; carry-in tied low, carry-out not needed.
  rca_16bit u_acc_add (
    .a    (acc_q),
    .b    (term),
    .c    (1'b0),
    .sum  (sum),
    .cout (add_cout_unused)
  );

  // Multiply the current tap, rescale Q2.30 back to Q1.15, and resolve overflow.
  always_comb begin
    prod     = x_q[idx_q] * coef_q[idx_q];
    term     = DW'(prod >>> QSHIFT);
    add_ovf  = (acc_q[DW-1] == term[DW-1]) && (sum[DW-1] != acc_q[DW-1]);
`ifdef FIR_ACC_SAT_EN
    if (add_ovf) begin
      acc_next = acc_q[DW-1] ? 16'sh8000 : 16'sh7FFF;
    end else begin
      acc_next = $signed(sum);
    end
`else
    acc_next = $signed(sum);
`endif
  end

  // Next-state and control decode for IDLE -> ACC -> OUT.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    acc_step = 1'b0;
    cfg_wr   = bus.cfg_we && (state_q == IDLE) && (int'(bus.cfg_addr) < NTAPS);
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_step = 1'b1;
        if (idx_q == AW'(NTAPS - 1)) state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any partial or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Coefficient file, delay line and accumulator; the delay line moves only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= '0;
      end
      acc_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (cfg_wr) coef_q[bus.cfg_addr] <= $signed(bus.cfg_data);
      if (accept) begin
        x_q[0] <= $signed(bus.in_data);
        for (int k = 1; k < NTAPS; k++) x_q[k] <= x_q[k-1];
        acc_q <= '0;
        idx_q <= '0;
        ovf_q <= 1'b0;
      end else if (acc_step) begin
        acc_q <= acc_next;
        idx_q <= idx_q + 1'b1;
        ovf_q <= ovf_q | add_ovf;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = acc_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Directed bench for fir_tap_scheduler (NTAPS=8) with hand-computed expectations.
// Latency: n/a.
// Backpressure: exercises held results under out_ready=0.
module tb_fir_tap_scheduler;

  localparam int NTAPS = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fir_tap_scheduler_if #(.NTAPS(NTAPS)) bus ();

  fir_tap_scheduler #(.NTAPS(NTAPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] v);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = v;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic send(input logic [15:0] v, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic recv(output logic [15:0] d, output logic o, output bit ok);
    ok = 1'b0;
    d  = '0;
    o  = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        d = bus.out_data;
        o = bus.ovf;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h want=0000", bus.out_data); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_impulse;
    logic [15:0] ins [4];
    logic [15:0] exp_d [4];
    logic [15:0] d;
    logic        o;
    bit          ok;
    int          lat;
    ins   = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
    exp_d = '{16'h2000, 16'h1000, 16'h0000, 16'h0000};
    cfg_write(3'd0, 16'h4000);
    cfg_write(3'd1, 16'h2000);
    for (int n = 0; n < 4; n++) begin
      send(ins[n], ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL impulse_accept[%0d] timed out", n); end
      if (n == 0) begin
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
          @(posedge clk);
          #1;
          lat++;
        end
        total++; if (lat != NTAPS + 1) begin bad++; $display("FAIL impulse_latency got=%0d want=%0d", lat, NTAPS + 1); end
      end
      recv(d, o, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL impulse_result[%0d] timed out", n); end
      total++; if (d !== exp_d[n]) begin bad++; $display("FAIL impulse_data[%0d] got=%h want=%h", n, d, exp_d[n]); end
      total++; if (o !== 1'b0) begin bad++; $display("FAIL impulse_ovf[%0d] got=%b want=0", n, o); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    logic        o;
    bit          ok;
    bit          seen;
    send(16'h4000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_accept timed out"); end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL bp_out_valid never rose"); end
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", i, bus.out_valid); end
      total++; if (bus.out_data !== 16'h2000) begin bad++; $display("FAIL bp_hold_data[%0d] got=%h want=2000", i, bus.out_data); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bp_not_yet_consumed busy got=%b want=0", bus.busy); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_out got=%b want=1", bus.in_ready); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL bp_consumed busy got=%b want=1", bus.busy); end
    recv(d, o, ok);
    total++; if (d !== 16'h191A) begin bad++; $display("FAIL bp_next_data got=%h want=191a", d); end
  endtask

  task automatic test_overflow;
    logic [15:0] d;
    logic        o;
    logic [15:0] want;
    bit          ok;
`ifdef FIR_ACC_SAT_EN
    want = 16'h7FFF;
`else
    want = 16'hFFF0;
`endif
    for (int k = 0; k < NTAPS; k++) cfg_write(3'(k), 16'h7FFF);
    d = '0;
    o = 1'b0;
    for (int n = 0; n < NTAPS; n++) begin
      send(16'h7FFF, ok);
      recv(d, o, ok);
    end
    total++; if (d !== want) begin bad++; $display("FAIL ovf_data got=%h want=%h", d, want); end
    total++; if (o !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", o); end
  endtask

  task automatic test_cfg_during_acc;
    logic [15:0] d;
    logic        o;
    bit          ok;
    cfg_write(3'd0, 16'h4000);
    for (int k = 1; k < NTAPS; k++) cfg_write(3'(k), 16'h0000);
    send(16'h4000, ok);
    @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL cfgacc_busy got=%b want=1", bus.busy); end
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 16'h7FFF;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    recv(d, o, ok);
    total++; if (d !== 16'h2000) begin bad++; $display("FAIL cfgacc_first got=%h want=2000", d); end
    send(16'h4000, ok);
    recv(d, o, ok);
    total++; if (d !== 16'h2000) begin bad++; $display("FAIL cfgacc_old_coef got=%h want=2000", d); end
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL cfgidle_ready got=%b want=1", bus.in_ready); end
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 16'h7FFF;
    bus.in_valid = 1'b1; bus.in_data = 16'h4000;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    bus.in_valid = 1'b0;
    recv(d, o, ok);
    total++; if (d !== 16'h3FFF) begin bad++; $display("FAIL cfgidle_new_coef got=%h want=3fff", d); end
  endtask

  task automatic test_mid_reset;
    logic [15:0] d;
    logic        o;
    bit          ok;
    bit          seen;
    send(16'h4000, ok);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h4000, ok);
    @(posedge clk);
    @(posedge clk);
    #2;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_acc_busy_before got=%b want=1", bus.busy); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_acc_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_acc_busy got=%b want=0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", bus.in_ready); end
    send(16'h4000, ok);
    recv(d, o, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rst_impulse timed out"); end
    total++; if (d !== 16'h0000) begin bad++; $display("FAIL rst_impulse_data got=%h want=0000", d); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL rst_impulse_ovf got=%b want=0", o); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_impulse();
    test_back_to_back();
    test_overflow();
    test_cfg_during_acc();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
